// File: rtl/temp_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : temp_pkt_tx
// Description : Serialises a 32-bit sample behind a one-byte header as a
//               5-byte MSB-first frame, framed by serial_en with inter-byte gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module temp_pkt_tx #(
    parameter logic [7:0] HDR_TEMP   = 8'hA5,
    parameter logic [7:0] HDR_ALT    = 8'hC3,
    parameter int         GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        hdr_sel,
    input  logic        valid,
    output logic        ready,
    output logic        serial_data,
    output logic        serial_en,
    output logic        done
);

    localparam logic [3:0] c_GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam logic [2:0] c_LAST_BYTE = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [39:0] r_sr;
    logic [39:0] w_sr_nxt;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_nxt;
    logic [2:0]  r_byte_cnt;
    logic [2:0]  w_byte_nxt;
    logic [3:0]  r_gap_cnt;
    logic [3:0]  w_gap_nxt;
    logic        r_serial_data;
    logic        r_serial_en;
    logic        r_done;
    logic        w_done_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_sr          <= '0;
            r_bit_cnt     <= '0;
            r_byte_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_serial_data <= 1'b0;
            r_serial_en   <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sr          <= w_sr_nxt;
            r_bit_cnt     <= w_bit_nxt;
            r_byte_cnt    <= w_byte_nxt;
            r_gap_cnt     <= w_gap_nxt;
            // Outputs are registered from the next state so they line up
            // with the cycle in which that state is active.
            r_serial_en   <= (w_state_nxt == S_SHIFT);
            r_serial_data <= (w_state_nxt == S_SHIFT) & w_sr_nxt[39];
            r_done        <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_bit_nxt   = r_bit_cnt;
        w_byte_nxt  = r_byte_cnt;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            S_IDLE: begin
                if (valid && ready) begin
                    w_sr_nxt    = {(hdr_sel ? HDR_ALT : HDR_TEMP), data_in};
                    w_byte_nxt  = 3'd0;
                    w_bit_nxt   = 3'd7;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_sr_nxt = {r_sr[38:0], 1'b0};
                if (r_bit_cnt == 3'd0) begin
                    w_gap_nxt   = c_GAP_LAST;
                    w_state_nxt = S_GAP;
                end else begin
                    w_bit_nxt = r_bit_cnt - 3'd1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    if (r_byte_cnt == c_LAST_BYTE) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_byte_nxt  = r_byte_cnt + 3'd1;
                        w_bit_nxt   = 3'd7;
                        w_state_nxt = S_SHIFT;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt - 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // done marks the final gap cycle of the last byte.
    always_comb begin
        w_done_nxt = (w_state_nxt == S_GAP) && (w_gap_nxt == 4'd0) &&
                     (w_byte_nxt == c_LAST_BYTE);
    end

    assign ready       = (r_state == S_IDLE);
    assign serial_data = r_serial_data;
    assign serial_en   = r_serial_en;
    assign done        = r_done;

endmodule
`default_nettype wire
